bfloat16_rf_ctrl: RTL and testbench

BFLOAT16_RF_CTRL -- requirements
Module: bfloat16_rf_ctrl

---
 rtl/bfloat16_rf_ctrl.sv | 114 +++++++++++
 tb/tb_bfloat16_rf_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfloat16_rf_ctrl.sv
// Two-port round-robin front end for a bfloat16 register file, with a
// zero-fill sequencer that takes the file over for DEPTH cycles.
module bfloat16_rf_ctrl #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_di,
  input  logic [DATA_W-1:0] rf_dout
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              last_a;     // A held the most recent grant
  logic              grant_ok;
  logic              clearing;

  // A clear request or a reset in progress blocks arbitration this cycle.
  assign grant_ok = (state == IDLE) && !rst_x && !clr_start;
  assign clearing = (state == CLEAR) && !rst_x;

  assign a_gnt = grant_ok && a_req && (!b_req || !last_a);
  assign b_gnt = grant_ok && b_req && (!a_req ||  last_a);

  // NOTE: every output gets a default first, so no path leaves a latch behind.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_di   = '0;
    if (clearing) begin
      rf_we   = 1'b1;
      rf_addr = cnt;
    end else if (a_gnt) begin
      rf_we   = a_we;
      rf_addr = a_addr;
      rf_di   = a_wdata;
    end else if (b_gnt) begin
      rf_we   = b_we;
      rf_addr = b_addr;
      rf_di   = b_wdata;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst_x) begin
      state    <= IDLE;
      cnt      <= '0;
      last_a   <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST_ADDR) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (a_gnt)      last_a <= 1'b1;
      else if (b_gnt) last_a <= 1'b0;

      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= rf_dout;
      if (b_gnt && !b_we) b_rdata <= rf_dout;
    end
  end

endmodule

// File: tb/tb_bfloat16_rf_ctrl.sv
// Scoreboard bench for bfloat16_rf_ctrl: a behavioural model predicts grants,
// register-file traffic and clear status; a monitor checks read responses.
module tb_bfloat16_rf_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_x, clr_start, clr_busy, clr_done;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_di, rf_dout;

  always #5 clk = ~clk;

  bfloat16_rf_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_x(rst_x), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_di(rf_di), .rf_dout(rf_dout)
  );

  // Register file the controller drives: combinational read, clocked write.
  logic [DW-1:0] rf_mem [DEPTH];
  assign rf_dout = rf_mem[rf_addr];
  always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_di;

  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
  typedef struct {logic [DW-1:0] data; int cyc;} rd_t;

  cmd_t          a_cq[$], b_cq[$];
  rd_t           a_eq[$], b_eq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] a_last, b_last;
  int            clear_left, done_pend, cyc, n_vec, n_fail;
  bit            last_a_won, a_gs, b_gs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input bit side, input logic we, input int addr, input logic [DW-1:0] data);
    cmd_t c;
    c = '{we: we, addr: AW'(addr), data: data};
    if (side) b_cq.push_back(c); else a_cq.push_back(c);
  endtask

  task automatic refill();
    cmd_t c;
    if (!a_req && a_cq.size() > 0) begin
      c = a_cq.pop_front();
      a_req = 1'b1; a_we = c.we; a_addr = c.addr; a_wdata = c.data;
    end
    if (!b_req && b_cq.size() > 0) begin
      c = b_cq.pop_front();
      b_req = 1'b1; b_we = c.we; b_addr = c.addr; b_wdata = c.data;
    end
  endtask

  // Predict this cycle's outputs from the rules, compare, then advance the model past the edge.
  task automatic model_eval();
    bit            ea, eb, ebusy, edone;
    logic          ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edi;
    ea = 0; eb = 0; ewe = 0; eaddr = '0; edi = '0;
    ebusy = (clear_left > 0);
    edone = (done_pend != 0);
    if (!rst_x) begin
      if (clear_left > 0) begin
        ewe   = 1'b1;
        eaddr = AW'(DEPTH - clear_left);
      end else if (done_pend == 0 && !clr_start) begin
        if (a_req && b_req) begin
          ea = !last_a_won; eb = last_a_won;
        end else begin
          ea = a_req; eb = b_req;
        end
        if (ea)      begin ewe = a_we; eaddr = a_addr; edi = a_wdata; end
        else if (eb) begin ewe = b_we; eaddr = b_addr; edi = b_wdata; end
      end
    end
    check("grants", {a_gnt, b_gnt}, {ea, eb});
    check("rf_bus", {rf_we, rf_addr, rf_di}, {ewe, eaddr, edi});
    check("clr_status", {clr_busy, clr_done}, {ebusy, edone});
    a_gs = a_gnt;
    b_gs = b_gnt;

    if (rst_x) begin
      clear_left = 0; done_pend = 0; last_a_won = 0; a_last = '0; b_last = '0;
    end else if (clear_left > 0) begin
      ref_mem[eaddr] = '0;
      clear_left--;
      if (clear_left == 0) done_pend = 1;
    end else if (done_pend != 0) begin
      done_pend = 0;
    end else if (clr_start) begin
      clear_left = DEPTH;
    end else if (ea) begin
      last_a_won = 1;
      if (a_we) ref_mem[a_addr] = a_wdata;
      else a_eq.push_back('{data: ref_mem[a_addr], cyc: cyc + 1});
    end else if (eb) begin
      last_a_won = 0;
      if (b_we) ref_mem[b_addr] = b_wdata;
      else b_eq.push_back('{data: ref_mem[b_addr], cyc: cyc + 1});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    if (a_gs) a_req = 1'b0;
    if (b_gs) b_req = 1'b0;
    refill();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((a_req || b_req || a_cq.size() > 0 || b_cq.size() > 0 || a_eq.size() > 0 ||
            b_eq.size() > 0 || clear_left > 0 || done_pend != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles", budget);
    end
  endtask

  // Read-response monitor, one call per requester.
  task automatic mon(input bit s);
    logic          v;
    logic [DW-1:0] d;
    rd_t           e;
    bit            have;
    string         p;
    p    = s ? "b" : "a";
    v    = s ? b_rvalid : a_rvalid;
    d    = s ? b_rdata : a_rdata;
    have = s ? (b_eq.size() > 0) : (a_eq.size() > 0);
    if (have) e = s ? b_eq[0] : a_eq[0];
    if (v) begin
      if (!have) begin
        n_vec++; n_fail++;
        $display("FAIL %s_rvalid_unexpected: rvalid=1, expected no response (cycle %0d)", p, cyc);
      end else begin
        if (s) void'(b_eq.pop_front()); else void'(a_eq.pop_front());
        check({p, "_rvalid_cycle"}, 64'(cyc), 64'(e.cyc));
        check({p, "_rdata"}, d, e.data);
        if (s) b_last = e.data; else a_last = e.data;
      end
    end else begin
      check({p, "_rdata_hold"}, d, s ? b_last : a_last);
      if (have && e.cyc <= cyc) begin
        if (s) void'(b_eq.pop_front()); else void'(a_eq.pop_front());
        n_vec++; n_fail++;
        $display("FAIL %s_rvalid_missing: rvalid=0, expected 1 with data %0h (cycle %0d)", p, e.data, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_x) begin
      mon(1'b0);
      mon(1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_x = 1'b1; clr_start = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin rf_mem[i] = '0; ref_mem[i] = '0; end
    clear_left = 0; done_pend = 0; last_a_won = 0; a_last = '0; b_last = '0;
    cyc = 0; n_vec = 0; n_fail = 0; a_gs = 0; b_gs = 0;

    // A request held through reset must wait for reset release.
    push_cmd(0, 1'b0, 7, '0);
    refill();
    cycle(); cycle();
    rst_x = 1'b0;
    drain(50);

    // Write 0x3F80 to addr 3, then read it back.
    push_cmd(0, 1'b1, 3, 16'h3F80);
    push_cmd(0, 1'b0, 3, '0);
    refill();
    drain(50);

    // Both requesters streaming reads: grants alternate.
    push_cmd(0, 1'b1, 5, 16'h4049);
    push_cmd(1, 1'b1, 6, 16'hC0A0);
    refill();
    drain(50);
    for (int i = 0; i < 4; i++) begin
      push_cmd(0, 1'b0, 5, '0);
      push_cmd(1, 1'b0, 6, '0);
    end
    refill();
    drain(100);

    // Randomised mix, with occasional clear requests in any state.
    for (int i = 0; i < 400; i++) begin
      if (a_cq.size() < 2 && $urandom_range(0, 1) == 1)
        push_cmd(0, 1'($urandom), int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      if (b_cq.size() < 2 && $urandom_range(0, 1) == 1)
        push_cmd(1, 1'($urandom), int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      refill();
      clr_start = ($urandom_range(0, 59) == 0);
      cycle();
      clr_start = 1'b0;
    end
    drain(300);

    // Fill every entry, clear, read everything back.
    for (int i = 0; i < DEPTH; i++) push_cmd(0, 1'b1, i, DW'(16'h0101 * (i + 1)));
    refill();
    drain(200);
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    drain(100);
    for (int i = 0; i < DEPTH; i++) push_cmd(i % 2 == 1, 1'b0, i, '0);
    refill();
    drain(200);

    // Clear request and a read in the same cycle: the clear wins.
    push_cmd(0, 1'b1, 3, 16'hBF80);
    refill();
    drain(20);
    push_cmd(0, 1'b0, 3, '0);
    refill();
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    drain(100);

    // Reset while the clear counter is at 10.
    for (int i = 0; i < DEPTH; i++) push_cmd(1, 1'b1, i, DW'(16'h4000 + i));
    refill();
    drain(200);
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    repeat (10) cycle();
    rst_x = 1'b1;
    cycle();
    rst_x = 1'b0;
    cycle();
    for (int i = 0; i < DEPTH; i++) push_cmd(0, 1'b0, i, '0);
    refill();
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
